// File: rtl/sonar_echo_emu.sv
// Ultrasonic range sensor responder: validates the trig width, waits the burst
// time, then drives a configurable-width echo followed by a trig hold-off.
module sonar_echo_emu #(
   parameter int unsigned TRIG_MIN_CYC = 500,
   parameter int unsigned BURST_CYC    = 10000,
   parameter int unsigned ECHO_MAX_CYC = 1900000,
   parameter int unsigned HOLDOFF_CYC  = 3000000
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        trig,
   output logic        echo,
   input  logic [31:0] cfg_echo_cyc,
   input  logic        cfg_drop,
   output logic        busy,
   output logic        err_short_trig,
   output logic [15:0] cnt_resp
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_TWID  = 3'd1;
   localparam logic [2:0] S_BURST = 3'd2;
   localparam logic [2:0] S_ECHO  = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   localparam logic [31:0] LP_TRIG_MIN   = 32'(TRIG_MIN_CYC);
   localparam logic [31:0] LP_BURST_LAST = 32'(BURST_CYC - 1);
   localparam logic [31:0] LP_ECHO_MAX   = 32'(ECHO_MAX_CYC);
   localparam logic [31:0] LP_HOLD_LAST  = 32'(HOLDOFF_CYC - 1);

   logic        r_trig_meta;
   logic        r_trig_s;
   logic        r_trig_d;
   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic [31:0] r_cnt;
   logic [15:0] r_width;
   logic [31:0] r_cfg;
   logic        r_drop;
   logic [31:0] w_len;
   logic        r_echo;
   logic        r_busy;
   logic        r_err;
   logic [15:0] r_cnt_resp;
   logic        w_rise;

   assign w_rise         = r_trig_s & ~r_trig_d;
   assign echo           = r_echo;
   assign busy           = r_busy;
   assign err_short_trig = r_err;
   assign cnt_resp       = r_cnt_resp;

   // Echo length from the values latched at trig fall; 0 is promoted to 1.
   always_comb begin
      w_len = r_cfg;
      if (r_drop || (r_cfg > LP_ECHO_MAX)) begin
         w_len = LP_ECHO_MAX;
      end else if (r_cfg == 32'd0) begin
         w_len = 32'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_rise) w_state_nxt = S_TWID;
         S_TWID:  if (!r_trig_s) begin
                     w_state_nxt = ({16'd0, r_width} >= LP_TRIG_MIN) ? S_BURST : S_IDLE;
                  end
         S_BURST: if (r_cnt == LP_BURST_LAST) w_state_nxt = S_ECHO;
         S_ECHO:  if (r_cnt == (w_len - 32'd1)) w_state_nxt = S_HOLD;
         S_HOLD:  if (r_cnt == LP_HOLD_LAST) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // echo and busy are registered from the next state so they align with r_state.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_trig_meta <= 1'b0;
         r_trig_s    <= 1'b0;
         r_trig_d    <= 1'b0;
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_width     <= '0;
         r_cfg       <= '0;
         r_drop      <= 1'b0;
         r_echo      <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_cnt_resp  <= '0;
      end else begin
         r_trig_meta <= trig;
         r_trig_s    <= r_trig_meta;
         r_trig_d    <= r_trig_s;
         r_state     <= w_state_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_echo      <= (w_state_nxt == S_ECHO);
         r_err       <= (r_state == S_TWID) && (w_state_nxt == S_IDLE);

         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if ((r_state == S_BURST) || (r_state == S_ECHO) || (r_state == S_HOLD)) begin
            r_cnt <= r_cnt + 32'd1;
         end

         if ((r_state == S_IDLE) && w_rise) begin
            r_width <= 16'd1;
         end else if ((r_state == S_TWID) && r_trig_s && (r_width != 16'hFFFF)) begin
            r_width <= r_width + 16'd1;
         end

         if ((r_state == S_TWID) && (w_state_nxt == S_BURST)) begin
            r_cfg  <= cfg_echo_cyc;
            r_drop <= cfg_drop;
         end

         if ((r_state == S_ECHO) && (w_state_nxt == S_HOLD)) begin
            r_cnt_resp <= r_cnt_resp + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sonar_echo_emu.sv
// Scoreboard bench for sonar_echo_emu: expected echo widths and trig-fall times
// are queued by the stimulus tasks and checked by a monitor on every echo pulse.
`timescale 1ns/1ps
module tb_sonar_echo_emu;

   localparam int unsigned TRIG_MIN = 10;
   localparam int unsigned BURST    = 20;
   localparam int unsigned EMAX     = 2000;
   localparam int unsigned HOLD     = 100;
   // pin fall -> trig_s low (2 sync flops) -> sampled low (1) -> burst
   localparam int unsigned RISE_LAT = 2 + 1 + BURST;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic        trig    = 1'b0;
   logic        cfg_drop = 1'b0;
   logic [31:0] cfg_echo_cyc = '0;
   logic        echo;
   logic        busy;
   logic        err_short_trig;
   logic [15:0] cnt_resp;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   int unsigned exp_w[$];
   int unsigned fall_q[$];
   logic [15:0] exp_cnt = '0;
   int err_seen = 0;

   sonar_echo_emu #(
      .TRIG_MIN_CYC(TRIG_MIN),
      .BURST_CYC(BURST),
      .ECHO_MAX_CYC(EMAX),
      .HOLDOFF_CYC(HOLD)
   ) dut (
      .clk_sys(clk_sys),
      .rst_n(rst_n),
      .trig(trig),
      .echo(echo),
      .cfg_echo_cyc(cfg_echo_cyc),
      .cfg_drop(cfg_drop),
      .busy(busy),
      .err_short_trig(err_short_trig),
      .cnt_resp(cnt_resp)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc++;

   // Monitor: sampled 1 ns after each rising edge.
   logic e_prev = 1'b0, b_prev = 1'b0, r_prev = 1'b0;
   bit hold_pend = 1'b0;
   int unsigned hi = 0, fall_at = 0, t_fall, t_w;
   always @(posedge clk_sys) begin
      #1;
      if (!rst_n) begin
         e_prev = 1'b0; b_prev = 1'b0; r_prev = 1'b0; hold_pend = 1'b0; hi = 0;
      end else begin
         if (echo && !e_prev) begin
            hi = 1;
            checks++;
            if (fall_q.size() == 0) begin
               errors++;
               $display("FAIL echo_rise_unexpected: echo=1 at cyc %0d, required 0", cyc);
            end else begin
               t_fall = fall_q.pop_front();
               if ((cyc - t_fall) !== RISE_LAT) begin
                  errors++;
                  $display("FAIL echo_rise_delay: got %0d cycles, required %0d", cyc - t_fall, RISE_LAT);
               end
            end
         end else if (echo) begin
            hi++;
         end
         if (!echo && e_prev) begin
            checks++;
            if (exp_w.size() == 0) begin
               errors++;
               $display("FAIL echo_width: pulse of %0d with no expectation queued", hi);
            end else begin
               t_w = exp_w.pop_front();
               if (hi !== t_w) begin
                  errors++;
                  $display("FAIL echo_width: got %0d, required %0d", hi, t_w);
               end
            end
            exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (cnt_resp !== exp_cnt) begin
               errors++;
               $display("FAIL cnt_resp_at_fall: got %0d, required %0d", cnt_resp, exp_cnt);
            end
            fall_at = cyc;
            hold_pend = 1'b1;
         end
         if (!busy && b_prev && hold_pend) begin
            checks++;
            if ((cyc - fall_at) !== HOLD) begin
               errors++;
               $display("FAIL busy_holdoff: got %0d cycles, required %0d", cyc - fall_at, HOLD);
            end
            hold_pend = 1'b0;
         end
         if (err_short_trig) begin
            checks++;
            if (r_prev !== 1'b0) begin
               errors++;
               $display("FAIL err_pulse_width: err high on consecutive cycles, required 1 cycle");
            end
            if (!r_prev) err_seen++;
         end
         e_prev = echo; b_prev = busy; r_prev = err_short_trig;
      end
   end

   task automatic legal_trig(input int n, input int unsigned exp_len);
      @(negedge clk_sys);
      trig = 1'b1;
      repeat (n) @(negedge clk_sys);
      trig = 1'b0;
      fall_q.push_back(cyc);
      exp_w.push_back(exp_len);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((busy || exp_w.size() != 0) && k < 6000) begin
         @(posedge clk_sys); #1; k++;
      end
      checks++;
      if (k >= 6000) begin
         errors++;
         $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle", name, busy, exp_w.size());
      end
   endtask

   task automatic wait_echo(input logic lvl, input string name);
      int k = 0;
      while (echo !== lvl && k < 3000) begin
         @(posedge clk_sys); #1; k++;
      end
      checks++;
      if (k >= 3000) begin
         errors++;
         $display("FAIL %s_echo_wait: echo=%0b, required %0b", name, echo, lvl);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_sys);
      checks++;
      if ({echo, busy, err_short_trig, cnt_resp} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: echo=%0b busy=%0b err=%0b cnt=%0d, required all 0",
                  echo, busy, err_short_trig, cnt_resp);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic test_normal();
      cfg_drop = 1'b0; cfg_echo_cyc = 32'd500;
      legal_trig(12, 500);
      wait_idle("normal");
      checks++;
      if (cnt_resp !== 16'd1) begin
         errors++;
         $display("FAIL normal_cnt: got %0d, required 1", cnt_resp);
      end
   endtask

   task automatic test_short_trig();
      int e0 = err_seen;
      logic [15:0] c0 = cnt_resp;
      @(negedge clk_sys);
      trig = 1'b1;
      repeat (5) @(negedge clk_sys);
      trig = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      checks++;
      if (err_short_trig !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL short_err_busy: err=%0b busy=%0b, required err=1 busy=0", err_short_trig, busy);
      end
      @(posedge clk_sys); #1;
      checks++;
      if (err_short_trig !== 1'b0) begin
         errors++;
         $display("FAIL short_err_clear: err=%0b, required 0", err_short_trig);
      end
      repeat (40) @(posedge clk_sys);
      #1;
      checks++;
      if (cnt_resp !== c0 || err_seen !== e0 + 1 || echo !== 1'b0) begin
         errors++;
         $display("FAIL short_after: cnt=%0d errs=%0d echo=%0b, required cnt=%0d errs=%0d echo=0",
                  cnt_resp, err_seen, echo, c0, e0 + 1);
      end
   endtask

   task automatic test_drop();
      logic [15:0] c0 = cnt_resp;
      cfg_drop = 1'b1; cfg_echo_cyc = 32'd500;
      for (int i = 0; i < 3; i++) begin
         legal_trig(12, EMAX);
         wait_idle("drop");
      end
      checks++;
      if (cnt_resp !== c0 + 16'd3) begin
         errors++;
         $display("FAIL drop_cnt: got %0d, required %0d", cnt_resp, c0 + 16'd3);
      end
      cfg_drop = 1'b0;
   endtask

   task automatic test_clamp();
      cfg_echo_cyc = 32'd5000;
      legal_trig(12, EMAX);
      wait_idle("clamp_hi");
      cfg_echo_cyc = 32'd0;
      legal_trig(12, 1);
      wait_idle("clamp_zero");
      cfg_echo_cyc = 32'd300;
      legal_trig(12, 300);
      repeat (10) @(negedge clk_sys);
      cfg_echo_cyc = 32'd50;
      wait_idle("cfg_change");
   endtask

   task automatic test_retrigger();
      int e0 = err_seen;
      cfg_echo_cyc = 32'd500;
      legal_trig(12, 500);
      wait_echo(1'b1, "retrig");
      repeat (10) @(negedge clk_sys);
      trig = 1'b1;
      repeat (12) @(negedge clk_sys);
      trig = 1'b0;
      wait_echo(1'b0, "retrig");
      repeat (20) @(negedge clk_sys);
      trig = 1'b1;
      repeat (5) @(negedge clk_sys);
      trig = 1'b0;
      wait_idle("retrig");
      repeat (50) @(negedge clk_sys);
      checks++;
      if (busy !== 1'b0 || err_seen !== e0) begin
         errors++;
         $display("FAIL retrig_ignored: busy=%0b errs=%0d, required busy=0 errs=%0d", busy, err_seen, e0);
      end
      // trig held high across the end of hold-off must not start a cycle
      cfg_echo_cyc = 32'd30;
      legal_trig(12, 30);
      wait_echo(1'b1, "hold_across");
      wait_echo(1'b0, "hold_across");
      repeat (20) @(negedge clk_sys);
      trig = 1'b1;
      wait_idle("hold_across");
      repeat (30) @(negedge clk_sys);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_across_high: busy=%0b, required 0", busy);
      end
      trig = 1'b0;
      repeat (10) @(negedge clk_sys);
      checks++;
      if (busy !== 1'b0 || err_seen !== e0) begin
         errors++;
         $display("FAIL hold_across_fall: busy=%0b errs=%0d, required busy=0 errs=%0d", busy, err_seen, e0);
      end
      legal_trig(12, 30);
      wait_idle("after_hold_across");
   endtask

   task automatic test_reset_mid_echo();
      cfg_echo_cyc = 32'd500;
      legal_trig(12, 500);
      wait_echo(1'b1, "mid_reset");
      repeat (100) @(negedge clk_sys);
      rst_n = 1'b0;
      #1;
      checks++;
      if (echo !== 1'b0 || busy !== 1'b0 || cnt_resp !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: echo=%0b busy=%0b cnt=%0d, required all 0", echo, busy, cnt_resp);
      end
      exp_w.delete();
      fall_q.delete();
      exp_cnt = '0;
      repeat (3) @(negedge clk_sys);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      legal_trig(12, 500);
      wait_idle("post_reset");
      checks++;
      if (cnt_resp !== 16'd1) begin
         errors++;
         $display("FAIL post_reset_cnt: got %0d, required 1", cnt_resp);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_short_trig();
      test_drop();
      test_clamp();
      test_retrigger();
      test_reset_mid_echo();
      checks++;
      if (exp_w.size() != 0 || fall_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expect: widths=%0d rises=%0d, required 0", exp_w.size(), fall_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time exhausted, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sonar_echo_emu.md
Name: sonar_echo_emu

Overview:
- Emulates the ultrasonic range sensor, acting as the responder end of the trig/echo protocol.
- Watches the trig pulse driven by the measurement front end, checks its width, and waits a fixed burst time. It then drives an echo pulse whose width is set by a configuration input.
- Used on-board for loopback self-test of the measurement path and as a synthesizable bench model.
- Supports forced "no target" (max-width echo) to exercise the retry/timeout path upstream.

Parameters:
- TRIG_MIN_CYC, 500: minimum legal trig high width in clk_sys cycles (10 us at 50 MHz); range 1..65535.
- BURST_CYC, 10000: delay from trig fall to echo rise, modelling the 8-cycle 40 kHz burst.
- ECHO_MAX_CYC, 1900000: echo width for no target (38 ms); also the upper clamp for configured widths.
- HOLDOFF_CYC, 3000000: dead time after echo fall during which trig is ignored (60 ms).

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trig  in  1  trigger from measurement front end; asynchronous to clk_sys
- echo  out  1  emulated echo pulse, registered
- cfg_echo_cyc  in  32  requested echo width in clk_sys cycles
- cfg_drop  in  1  1 = no target; echo is ECHO_MAX_CYC wide
- busy  out  1  high whenever the FSM is not in S_IDLE
- err_short_trig  out  1  one-cycle pulse when a trig pulse shorter than TRIG_MIN_CYC is rejected
- cnt_resp  out  16  count of completed echo pulses; wraps at 16'hFFFF->0

Behaviour:
- Reset values and clocking:
  - Reset (rst_n low): all outputs 0, FSM in S_IDLE, all counters 0, synchronizer flops 0.
  - Asynchronous reset mid-operation forces echo low immediately.
  - All state is on clk_sys.
- Input synchronization: trig passes through a 2-flop synchronizer to give trig_s. A registered copy of trig_s gives rise/fall detection. All timing below is relative to trig_s, which adds 2 cycles of latency vs the pin.
- FSM states:
  - S_IDLE: on trig_s rising edge -> S_TWID, with the width counter loaded to 1. A trig that is already high on entry to S_IDLE does not start a cycle; a fresh rising edge is required.
  - S_TWID: the width counter increments each cycle while trig_s is high, saturating at 16'hFFFF. On trig_s low:
    - if width >= TRIG_MIN_CYC -> S_BURST, and cfg_echo_cyc and cfg_drop are latched in that cycle;
    - otherwise -> S_IDLE, with err_short_trig high for exactly 1 cycle.
  - S_BURST: counts BURST_CYC cycles, then -> S_ECHO. echo goes high exactly BURST_CYC cycles after the first cycle trig_s is sampled low.
  - S_ECHO: echo is high for exactly len cycles, then drops, and the FSM -> S_HOLD. cnt_resp increments in the cycle echo falls.
  - S_HOLD: counts HOLDOFF_CYC cycles, then -> S_IDLE.
  - Any other encoding -> S_IDLE.
- Echo length rule:
  - len = ECHO_MAX_CYC if latched drop = 1;
  - otherwise len = clamp(latched cfg, 1, ECHO_MAX_CYC). A cfg value of 0 gives a 1-cycle echo.
  - Comparison is unsigned, 32-bit.
- Trig in later states: trig edges during S_BURST, S_ECHO and S_HOLD are ignored with no error flag. Changes on cfg_* after the latch cycle have no effect on the current pulse.
- busy: busy = (state != S_IDLE). It is registered alongside state.
- Counters: each phase counter is 32-bit and cleared on every state change. There is no wrap inside a phase, because all parameters are < 2^32.
- Echo output: echo is driven directly from a flop and is glitch-free.

Test Plan:
(Bench parameters: TRIG_MIN_CYC=10, BURST_CYC=20, ECHO_MAX_CYC=2000, HOLDOFF_CYC=100.)
1. Normal measurement: trig high for 12 cycles, cfg_echo_cyc=500, cfg_drop=0 -> echo rises 20 cycles after trig_s falls and stays high exactly 500 cycles; cnt_resp=1; busy falls 100 cycles after echo falls.
2. Short trig: trig high for 5 cycles -> err_short_trig is a single-cycle pulse; echo stays 0; busy=0 one cycle after trig_s falls; cnt_resp unchanged.
3. Drop mode: cfg_drop=1, cfg_echo_cyc=500, legal trig -> echo high exactly 2000 cycles. Three consecutive trigs each give a 2000-cycle echo, and cnt_resp=3 (retry/timeout upstream).
4. Clamping: cfg_echo_cyc=5000 gives a 2000-cycle echo; cfg_echo_cyc=0 gives a 1-cycle echo. Changing cfg_echo_cyc to 50 during S_BURST leaves the echo width unchanged.
5. Retrigger immunity:
   - pulse trig during S_ECHO and again during S_HOLD -> no extra echo, no err_short_trig;
   - hold trig high across the end of S_HOLD -> no new cycle until trig falls and rises again.
6. Reset mid-echo: assert rst_n low 100 cycles into S_ECHO -> echo=0 immediately, cnt_resp=0, busy=0. After release, a legal trig produces a normal echo.
